// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial 8-bit adder: datapath width,
// bit-counter width and the sequencer state encoding.
package somador_pkg;

  // Operand / result width.
  localparam int unsigned WIDTH = 8;

  // Width of the bit counter that walks over the operand bits.
  localparam int unsigned CNT_W = 3;

  // Counter value at which the final (MSB) bit is processed.
  localparam logic [CNT_W-1:0] LAST_BIT = 3'd7;

  // Sequencer states: waiting, shifting bits through the adder cell,
  // and the single result-valid cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when the counter points at the last bit of the operands.
  function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt);
    return (cnt == LAST_BIT);
  endfunction

endpackage

// File: rtl/somador_completo.sv
// One-bit combinational full adder. The serial adder instantiates a single
// copy and reuses it for every bit position, LSB first.
module somador_completo (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  // Sum and carry of one bit position.
  always_comb begin
    S     = A ^ B ^ C_in;
    C_out = (A & B) | (A & C_in) | (B & C_in);
  end

endmodule

// File: rtl/somador_serial_8bits.sv
// Bit-serial 8-bit adder: {C_out,S} = A + B + C_in computed over eight
// cycles with one full-adder cell, LSB first, under a start/done handshake.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0 (state IDLE or DONE); A, B and C_in are sampled only at that edge.
// busy stays high while bits are being processed and requests seen then are
// dropped. done is a one-cycle pulse during which S/C_out (and V) are new;
// they hold until the next completion.
//
// Optional feature: define SOMADOR_SERIAL_OVF_EN to add the signed overflow
// output V (carry into bit 7 XOR carry out of bit 7), registered with S.
//
// The sequencer state is kept in state_q for observation by checkers.
module somador_serial_8bits
  import somador_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             start,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             busy,
  output logic             done
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             V
`endif
);

  // Sequencer state.
  state_t state_q, state_d;

  // Bit counter and carry flop.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;

  // Operand shift registers and the sum accumulator (fills from the MSB).
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Result registers, updated only on completion.
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

`ifdef SOMADOR_SERIAL_OVF_EN
  logic             v_q, v_d;
`endif

  // Full-adder cell outputs for the bit currently being processed.
  logic fa_s;
  logic fa_cout;

  // A new request can be taken whenever no addition is in flight.
  logic accept;
  // The bit being processed this cycle is the MSB.
  logic last_bit;

  assign accept   = start && (state_q != SHIFT);
  assign last_bit = (state_q == SHIFT) && is_last_bit(cnt_q);

  somador_completo u_fa (
    .A     (opa_q[0]),
    .B     (opb_q[0]),
    .C_in  (carry_q),
    .S     (fa_s),
    .C_out (fa_cout)
  );

  // Next-state logic: IDLE/DONE start a new addition on request, SHIFT runs
  // until the last bit and then raises done for exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: load operands on accept, shift one bit per cycle
  // in SHIFT, and publish the result when the last bit is processed.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    v_d     = v_q;
`endif

    if (accept) begin
      opa_d   = A;
      opb_d   = B;
      carry_d = C_in;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == SHIFT) begin
      acc_d   = {fa_s, acc_q[WIDTH-1:1]};
      opa_d   = {1'b0, opa_q[WIDTH-1:1]};
      opb_d   = {1'b0, opb_q[WIDTH-1:1]};
      carry_d = fa_cout;
      cnt_d   = cnt_q + 3'd1;
      if (last_bit) begin
        s_d    = {fa_s, acc_q[WIDTH-1:1]};
        cout_d = fa_cout;
`ifdef SOMADOR_SERIAL_OVF_EN
        // carry_q is still the carry into bit 7 during the last bit.
        v_d    = carry_q ^ fa_cout;
`endif
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset aborts any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SOMADOR_SERIAL_OVF_EN
  // Overflow flag, registered alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  assign V = v_q;
`endif

  assign S     = s_q;
  assign C_out = cout_q;
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_somador_serial_8bits.sv
// Self-checking bench for somador_serial_8bits. Expected results come from a
// 9-bit arithmetic model and are queued when a request is issued, then
// popped and compared when done pulses. Build with SOMADOR_SERIAL_OVF_EN to
// also cover the V output.
module tb_somador_serial_8bits;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       C_in;
  logic       start;
  logic [7:0] S;
  logic       C_out;
  logic       busy;
  logic       done;
  logic       v_obs;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic       V;
`endif

  int tests  = 0;
  int failed = 0;
  int hold_err = 0;

  // Expected {V, C_out, S} per issued request.
  logic [9:0] exp_q[$];
  // Expected value of {C_out,S} while no completion is happening.
  logic [8:0] held;

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  somador_serial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .start (start),
    .S     (S),
    .C_out (C_out),
    .busy  (busy),
    .done  (done)
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    .V     (V)
`endif
  );

`ifdef SOMADOR_SERIAL_OVF_EN
  always_comb v_obs = V;
`else
  always_comb v_obs = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin);
    logic [8:0] sum;
    logic       v;
    sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    v   = 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
    v   = (a[7] == b[7]) && (sum[7] != a[7]);
`endif
    return {v, sum};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; optionally queue its expected result.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input bit push);
    A     = a;
    B     = b;
    C_in  = cin;
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b, cin));
    tick();
    start = 1'b0;
  endtask

  // Wait for done (bounded), checking busy and result hold on the way, then
  // compare the result against the queue head.
  task automatic run_to_done(input string tag, input int elapsed);
    int         cyc;
    int         gaps;
    logic [9:0] exp;
    cyc  = elapsed;
    gaps = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy !== 1'b1) gaps++;
      if ({C_out, S} !== held) hold_err++;
      tick();
      cyc++;
    end
    check({tag, " latency"}, 16'(cyc), 16'd8);
    check({tag, " busy"}, 16'(gaps), 16'd0);
    check({tag, " busy_at_done"}, {15'd0, busy}, 16'd0);
    check({tag, " queue"}, 16'(exp_q.size()), 16'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, " result"}, {6'd0, v_obs, C_out, S}, {6'd0, exp});
      held = exp[8:0];
    end
  endtask

  // After a done, the pulse must drop and the result must hold.
  task automatic after_done(input string tag);
    tick();
    check({tag, " done_pulse"}, {15'd0, done}, 16'd0);
    check({tag, " hold"}, {7'd0, C_out, S}, {7'd0, held});
  endtask

  initial begin
    int rst_err;
    int ndone;
    logic [7:0] ra, rb;
    logic       rc;

    // Reset with random inputs and start held high.
    rst_n = 1'b0;
    start = 1'b1;
    A     = '0;
    B     = '0;
    C_in  = 1'b0;
    held  = '0;
    rst_err = 0;
    for (int i = 0; i < 6; i++) begin
      A    = 8'($urandom_range(0, 255));
      B    = 8'($urandom_range(0, 255));
      C_in = 1'($urandom_range(0, 1));
      tick();
      if ({S, C_out, busy, done, v_obs} !== 12'd0) rst_err++;
    end
    check("reset_all", 16'(rst_err), 16'd0);
    check("reset_S", {8'd0, S}, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_done", {15'd0, done}, 16'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {15'd0, busy}, 16'd0);

    // Basic additions.
    start_op(8'h3C, 8'h05, 1'b0, 1'b1);
    run_to_done("add_3c_05", 0);
    check("add_3c_05 S", {8'd0, S}, 16'h0041);
    after_done("add_3c_05");

    start_op(8'h10, 8'h20, 1'b1, 1'b1);
    run_to_done("add_cin", 0);
    check("add_cin S", {8'd0, S}, 16'h0031);
    after_done("add_cin");

    // Unsigned wrap.
    start_op(8'hFF, 8'h01, 1'b0, 1'b1);
    run_to_done("wrap", 0);
    check("wrap C_out", {15'd0, C_out}, 16'd1);
    check("wrap V", {15'd0, v_obs}, 16'd0);
    after_done("wrap");

`ifdef SOMADOR_SERIAL_OVF_EN
    // Signed overflow.
    start_op(8'h7F, 8'h01, 1'b0, 1'b1);
    run_to_done("ovf", 0);
    check("ovf V", {15'd0, v_obs}, 16'd1);
    after_done("ovf");
`endif

    // Start during bit cycle 3 must be ignored.
    start_op(8'h0A, 8'h0B, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    start_op(8'hF0, 8'hF0, 1'b0, 1'b0);
    run_to_done("ignored", 4);
    check("ignored S", {8'd0, S}, 16'h0015);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("ignored no_second_done", 16'(ndone), 16'd0);
    check("ignored idle", {15'd0, busy}, 16'd0);

    // Back-to-back with start held high.
    A     = 8'h80;
    B     = 8'h80;
    C_in  = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(8'h80, 8'h80, 1'b0));
    tick();
    run_to_done("b2b_first", 0);
    A = 8'h01;
    B = 8'h02;
    exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    tick();
    start = 1'b0;
    check("b2b restart_busy", {15'd0, busy}, 16'd1);
    check("b2b restart_done", {15'd0, done}, 16'd0);
    check("b2b hold", {7'd0, C_out, S}, 16'h0100);
    run_to_done("b2b_second", 0);
    after_done("b2b_second");

    // Random operands.
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc, 1'b1);
      run_to_done("random", 0);
      after_done("random");
    end

    // Reset during bit cycle 4 aborts the addition.
    start_op(8'h55, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {15'd0, busy}, 16'd0);
    check("abort S", {7'd0, C_out, S}, 16'd0);
    check("abort done", {15'd0, done}, 16'd0);
    held = '0;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("abort no_done", 16'(ndone), 16'd0);
    start_op(8'h01, 8'h01, 1'b0, 1'b1);
    run_to_done("after_abort", 0);
    check("after_abort S", {8'd0, S}, 16'h0002);
    after_done("after_abort");

    check("result_hold", 16'(hold_err), 16'd0);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
